// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: width defaults, HALT
// opcode encoding and the fetch state machine encoding.
package inst_fetch_pkg;

    localparam int         INST_W_DEF      = 32;
    localparam int         ADDR_W_DEF      = 16;
    localparam logic [5:0] HALT_OPCODE_DEF = 6'h3F;
    localparam int         OPC_MSB         = 31;
    localparam int         OPC_LSB         = 26;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_sync_fifo.sv
// Synchronous prefetch buffer with flush; the head entry is read straight
// from the storage registers so the consumer sees no extra combinational path.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is legal only when the head leaves on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC register drives memory directly, fetched
// words queue in a small prefetch buffer, and a HALT opcode stops fetching.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              INST_W      = INST_W_DEF,
    parameter int              ADDR_W      = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int              FIFO_DEPTH  = 2,
    parameter logic [5:0]      HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted
);

    fetch_state_t                  state_q;
    fetch_state_t                  state_d;
    logic [ADDR_W-1:0]             pc;
    logic                          fetch_en;
    logic                          push;
    logic                          pop;
    logic                          fetch_is_halt;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count_unused;
    logic [INST_W+ADDR_W-1:0]      fifo_rdata;

    assign imem_addr     = pc;
    assign fetch_is_halt = (imem_data[OPC_MSB:OPC_LSB] == HALT_OPCODE);
    assign pop           = inst_valid & inst_ready;
    assign push          = fetch_en & (~fifo_full | pop);
    assign inst_valid    = ~fifo_empty;
    assign {inst, inst_pc} = fifo_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (push && fetch_is_halt) state_d = HALTED;
            HALTED:  if (redirect_valid) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_en = (state_q == RUN) & ~redirect_valid;
        halted   = (state_q == HALTED);
    end

    // Redirect wins over sequential advance; the increment wraps at 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= START_ADDR;
        end else if (redirect_valid) begin
            pc <= redirect_addr;
        end else if (push) begin
            pc <= pc + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (INST_W + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({imem_data, pc}),
        .rdata (fifo_rdata),
        .count (fifo_count_unused),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: streaming to HALT, backpressure, redirect
// flush, PC wrap, mid-stream reset and restart from HALTED.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start2;
    logic [15:0] imem_addr, imem_addr2;
    logic [31:0] imem_data, imem_data2;
    logic [31:0] inst, inst2;
    logic [15:0] inst_pc, inst_pc2;
    logic        inst_valid, inst_valid2;
    logic        inst_ready;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        redirect_valid2;
    logic [15:0] redirect_addr2;
    logic        halted, halted2;
    logic [15:0] halt_addr;

    int vectors;
    int miscompares;

    inst_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halted(halted)
    );

    inst_fetch #(.START_ADDR(16'hFFFE)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .imem_addr(imem_addr2), .imem_data(imem_data2),
        .inst(inst2), .inst_pc(inst_pc2), .inst_valid(inst_valid2), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid2), .redirect_addr(redirect_addr2), .halted(halted2)
    );

    // Memory model: word at address a is 0x10+a, except a HALT at halt_addr.
    always_comb begin
        imem_data  = (imem_addr  == halt_addr) ? HALT_WORD : 32'h10 + {16'h0, imem_addr};
        imem_data2 = (imem_addr2 == halt_addr) ? HALT_WORD : 32'h10 + {16'h0, imem_addr2};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; redirect_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got=%b exp=0", halted); end
        vectors++; if (imem_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
        vectors++; if (inst !== 32'h0) begin miscompares++; $display("FAIL reset_inst got=%h exp=0", inst); end
        vectors++; if (inst_pc !== 16'h0) begin miscompares++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
        vectors++; if (imem_addr2 !== 16'hFFFE) begin miscompares++; $display("FAIL reset_addr2 got=%h exp=fffe", imem_addr2); end
        repeat (3) tick();
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid got=%b exp=0", inst_valid); end
        vectors++; if (imem_addr !== 16'h0000) begin miscompares++; $display("FAIL idle_addr got=%h exp=0000", imem_addr); end
    endtask

    task automatic test_stream_to_halt();
        do_reset();
        halt_addr = 16'd8; inst_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) begin
            logic [31:0] exp_inst;
            exp_inst = (i == 8) ? HALT_WORD : 32'h10 + i;
            vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, inst_valid); end
            vectors++; if (inst_pc !== 16'(i)) begin miscompares++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, inst_pc, 16'(i)); end
            vectors++; if (inst !== exp_inst) begin miscompares++; $display("FAIL stream_inst[%0d] got=%h exp=%h", i, inst, exp_inst); end
            vectors++; if (halted !== (i == 8)) begin miscompares++; $display("FAIL stream_halted[%0d] got=%b exp=%b", i, halted, (i == 8)); end
            tick();
        end
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL drained_valid got=%b exp=0", inst_valid); end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL drained_halted got=%b exp=1", halted); end
        vectors++; if (imem_addr !== 16'd9) begin miscompares++; $display("FAIL halted_addr got=%h exp=0009", imem_addr); end
    endtask

    task automatic test_halt_redirect();
        redirect_valid = 1'b1; redirect_addr = 16'h0004;
        tick();
        redirect_valid = 1'b0;
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL resume_halted got=%b exp=0", halted); end
        vectors++; if (dut.state_q !== RUN) begin miscompares++; $display("FAIL resume_state got=%0d exp=%0d", dut.state_q, RUN); end
        vectors++; if (imem_addr !== 16'h0004) begin miscompares++; $display("FAIL resume_addr got=%h exp=0004", imem_addr); end
        tick();
        vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL resume_valid got=%b exp=1", inst_valid); end
        vectors++; if (inst_pc !== 16'h0004) begin miscompares++; $display("FAIL resume_pc got=%h exp=0004", inst_pc); end
        vectors++; if (inst !== 32'h14) begin miscompares++; $display("FAIL resume_inst got=%h exp=00000014", inst); end
    endtask

    task automatic test_backpressure();
        do_reset();
        halt_addr = 16'h0100; inst_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        vectors++; if (imem_addr !== 16'h0002) begin miscompares++; $display("FAIL bp_addr got=%h exp=0002", imem_addr); end
        vectors++; if (dut.u_fifo.count !== 2'd2) begin miscompares++; $display("FAIL bp_count got=%0d exp=2", dut.u_fifo.count); end
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0) begin miscompares++; $display("FAIL bp_head got=%b/%h exp=1/0000", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        tick();
        vectors++; if (inst_pc !== 16'h0001 || inst !== 32'h11) begin miscompares++; $display("FAIL bp_second got=%h/%h exp=0001/00000011", inst_pc, inst); end
        tick();
        vectors++; if (inst_pc !== 16'h0002 || inst_valid !== 1'b1) begin miscompares++; $display("FAIL bp_third got=%h/%b exp=0002/1", inst_pc, inst_valid); end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        halt_addr = 16'h0100; inst_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vectors++; if (dut.u_fifo.count !== 2'd2 || inst_pc !== 16'h0) begin miscompares++; $display("FAIL rd_setup got=%0d/%h exp=2/0000", dut.u_fifo.count, inst_pc); end
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rd_flush_valid got=%b exp=0", inst_valid); end
        vectors++; if (imem_addr !== 16'h0020) begin miscompares++; $display("FAIL rd_addr got=%h exp=0020", imem_addr); end
        tick();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0020) begin miscompares++; $display("FAIL rd_target got=%b/%h exp=1/0020", inst_valid, inst_pc); end
        vectors++; if (inst !== 32'h30) begin miscompares++; $display("FAIL rd_inst got=%h exp=00000030", inst); end
    endtask

    task automatic test_pc_wrap();
        logic [15:0] exp_pc [3];
        exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000;
        do_reset();
        halt_addr = 16'h0100; inst_ready = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (inst_valid2 !== 1'b1 || inst_pc2 !== exp_pc[i]) begin miscompares++; $display("FAIL wrap[%0d] got=%b/%h exp=1/%h", i, inst_valid2, inst_pc2, exp_pc[i]); end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        halt_addr = 16'h0100; inst_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0002) begin miscompares++; $display("FAIL mid_running got=%b/%h exp=1/0002", inst_valid, inst_pc); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got=%b exp=0", inst_valid); end
        vectors++; if (imem_addr !== 16'h0000) begin miscompares++; $display("FAIL mid_addr got=%h exp=0000", imem_addr); end
        vectors++; if (halted !== 1'b0 || inst_pc !== 16'h0) begin miscompares++; $display("FAIL mid_state got=%b/%h exp=0/0000", halted, inst_pc); end
        repeat (3) tick();
        vectors++; if (inst_valid !== 1'b0 || imem_addr !== 16'h0000) begin miscompares++; $display("FAIL mid_nofetch got=%b/%h exp=0/0000", inst_valid, imem_addr); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_addr = 16'h0;
        redirect_valid2 = 1'b0; redirect_addr2 = 16'h0;
        halt_addr = 16'h0100;
        test_reset();
        test_stream_to_halt();
        test_halt_redirect();
        test_backpressure();
        test_redirect_flush();
        test_pc_wrap();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
